// File: rtl/return_address_stack.sv
// Return address stack for the fetch-stage branch predictor.
// A 16-entry circular stack of 32-bit return targets. It pushes on predicted
// calls and pops on predicted returns. The top entry is presented
// combinationally, so it lines up with the BTB lookup in the same cycle.
// The top index and occupancy are exported for branch checkpointing. A backend
// redirect restores them from a checkpoint.
// Optional feature: define RAS_RECURSION_CNT_EN to add a 3-bit repeat counter
// per entry. Repeated pushes of the same return address are then folded into
// one stack slot.
module return_address_stack (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] pc,
  input  logic        pred_valid,
  input  logic [1:0]  pred_type,
  input  logic [1:0]  pred_offset,
  input  logic        redirect_en,
  input  logic [3:0]  redirect_tos,
  input  logic [4:0]  redirect_count,
  output logic [31:0] ras_target,
  output logic        ras_valid,
  output logic [3:0]  ckpt_tos,
  output logic [4:0]  ckpt_count
);

  localparam logic [1:0] TYPE_CALL = 2'b01;
  localparam logic [1:0] TYPE_RET  = 2'b10;
  localparam logic [4:0] FULL      = 5'd16;

  logic [31:0] mem_q [16];
  logic [31:0] mem_d [16];
  logic [3:0]  tos_q, tos_d;
  logic [4:0]  count_q, count_d;
`ifdef RAS_RECURSION_CNT_EN
  logic [2:0]  rep_q [16];
  logic [2:0]  rep_d [16];
`endif

  logic        push;
  logic        pop;
  logic [31:0] ret_addr;
  logic [3:0]  tos_inc;
  logic [3:0]  tos_dec;

  // Next-state logic: redirect has priority over the predicted push or pop.
  always_comb begin
    push     = pred_valid && (pred_type == TYPE_CALL);
    pop      = pred_valid && (pred_type == TYPE_RET);
    // The call sits in word slot pred_offset. Skip the call and its delay slot.
    ret_addr = ((pc & 32'hFFFF_FFF0) | {28'd0, pred_offset, 2'b00}) + 32'd8;
    tos_inc  = tos_q + 4'd1;
    tos_dec  = tos_q - 4'd1;
    tos_d    = tos_q;
    count_d  = count_q;
    mem_d    = mem_q;
`ifdef RAS_RECURSION_CNT_EN
    rep_d    = rep_q;
`endif

    if (redirect_en) begin
      // Entry contents (and repeat counters) stay as they are.
      tos_d   = redirect_tos;
      count_d = (redirect_count > FULL) ? FULL : redirect_count;
    end else if (push) begin
`ifdef RAS_RECURSION_CNT_EN
      if ((count_q != 5'd0) && (ret_addr == mem_q[tos_q]) && (rep_q[tos_q] != 3'd7)) begin
        rep_d[tos_q] = rep_q[tos_q] + 3'd1;
      end else begin
        tos_d          = tos_inc;
        mem_d[tos_inc] = ret_addr;
        rep_d[tos_inc] = 3'd0;
        count_d        = (count_q == FULL) ? FULL : count_q + 5'd1;
      end
`else
      // When the stack is full, the oldest entry is overwritten.
      tos_d          = tos_inc;
      mem_d[tos_inc] = ret_addr;
      count_d        = (count_q == FULL) ? FULL : count_q + 5'd1;
`endif
    end else if (pop && (count_q != 5'd0)) begin
`ifdef RAS_RECURSION_CNT_EN
      if (rep_q[tos_q] != 3'd0) begin
        rep_d[tos_q] = rep_q[tos_q] - 3'd1;
      end else begin
        tos_d   = tos_dec;
        count_d = count_q - 5'd1;
      end
`else
      tos_d   = tos_dec;
      count_d = count_q - 5'd1;
`endif
    end
  end

  // State registers. Reset clears the pointers and every entry.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tos_q   <= 4'd0;
      count_q <= 5'd0;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 32'd0;
`ifdef RAS_RECURSION_CNT_EN
        rep_q[i] <= 3'd0;
`endif
      end
    end else begin
      tos_q   <= tos_d;
      count_q <= count_d;
      mem_q   <= mem_d;
`ifdef RAS_RECURSION_CNT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  // Zero-latency lookup of the current top, plus the checkpoint outputs.
  always_comb begin
    ras_target = mem_q[tos_q];
    ras_valid  = (count_q != 5'd0);
    ckpt_tos   = tos_q;
    ckpt_count = count_q;
  end

endmodule

// File: doc/return_address_stack.md
RETURN_ADDRESS_STACK -- requirements
Module: return_address_stack

Interface
REQ-001 The block SHALL have input clk, 1 bit, the clock; all state updates on its rising edge.
REQ-002 The block SHALL have input resetn, 1 bit, with synchronous, active-low reset.
REQ-003 The block SHALL have input pc, 32 bits, the fetch-group address currently presented to the branch target buffer.
REQ-004 The block SHALL have input pred_valid, 1 bit; high means the BTB prediction for pc is consumed this cycle.
REQ-005 The block SHALL have input pred_type, 2 bits, the BTB type: 00 direct, 01 call, 10 return, 11 indirect.
REQ-006 The block SHALL have input pred_offset, 2 bits, the BTB word slot of the branch within the 16-byte group.
REQ-007 The block SHALL have input redirect_en, 1 bit, the backend misprediction restore strobe.
REQ-008 The block SHALL have input redirect_tos, 4 bits, the checkpointed top-of-stack index.
REQ-009 The block SHALL have input redirect_count, 5 bits, the checkpointed occupancy, 0..16.
REQ-010 The block SHALL have output ras_target, 32 bits, the predicted return target, i.e. the entry at the current top.
REQ-011 The block SHALL have output ras_valid, 1 bit, high when occupancy != 0.
REQ-012 The block SHALL have output ckpt_tos, 4 bits, the current top index, provided for branch checkpointing.
REQ-013 The block SHALL have output ckpt_count, 5 bits, the current occupancy, provided for branch checkpointing.

Function
REQ-014 Storage SHALL be 16 entries x 32 bits, circular, indexed by a 4-bit tos with mod-16 wrap.
REQ-015 ras_target SHALL equal mem[tos] combinationally, giving zero-cycle lookup latency in the same cycle as the BTB output.
REQ-016 A push SHALL occur when pred_valid=1 and pred_type=01.
REQ-017 On push, the return address SHALL be {pc[31:4], pred_offset, 2'b00} + 8 (call plus delay slot), with 32-bit wrap and no carry out.
REQ-018 On push, tos SHALL become tos+1, mem[tos+1] SHALL be written with the return address, and count SHALL become min(count+1, 16).
REQ-019 A push at count=16 SHALL overwrite the oldest entry silently.
REQ-020 A pop SHALL occur when pred_valid=1 and pred_type=10.
REQ-021 On pop with count>0, tos SHALL become tos-1 and count SHALL become count-1.
REQ-022 On pop with count=0, no state SHALL change and ras_valid SHALL stay 0.
REQ-023 pred_type 00 or 11, or pred_valid=0, SHALL leave all state unchanged.
REQ-024 On redirect_en=1, the block SHALL load tos<=redirect_tos and count<=redirect_count, ignoring any push or pop in the same cycle.
REQ-025 The block SHALL not modify entry contents on redirect.
REQ-026 redirect_count>16 SHALL be treated as 16.
REQ-027 A push or pop SHALL be visible on ras_target, ras_valid, ckpt_tos and ckpt_count in the cycle after the edge.

Reset
REQ-028 While resetn=0 at a rising edge, the block SHALL set tos=0, count=0 and all entries to 0, so that ras_valid=0, ras_target=0, ckpt_tos=0 and ckpt_count=0.
REQ-029 Reset SHALL override redirect, push and pop in the same cycle.
REQ-030 The block SHALL accept valid operations from the first edge after resetn returns to 1.

Configuration
REQ-031 Macro RAS_RECURSION_CNT_EN SHALL control recursion compression as follows.
REQ-032 When RAS_RECURSION_CNT_EN is defined, each entry SHALL carry a 3-bit repeat counter, reset to 0.
REQ-033 When defined, a push whose address equals mem[tos], with count>0 and repeat<7, SHALL increment repeat only, leaving tos and count unchanged.
REQ-034 When defined, a pop with repeat[tos]>0 SHALL decrement repeat only; otherwise it SHALL pop normally.
REQ-035 When defined, writing a new entry SHALL clear its repeat counter, and redirect SHALL not restore repeat counters.
REQ-036 When RAS_RECURSION_CNT_EN is undefined, no repeat counters SHALL exist and every push and pop SHALL follow REQ-018 and REQ-021.

Verification
REQ-037 Bench SHALL check: reset, then push with pc=0x0040_0010 and offset=2 -> next cycle ras_target=0x0040_0020, ras_valid=1, ckpt_tos=1, ckpt_count=1.
REQ-038 Bench SHALL check: 3 pushes (A, B, C), then 3 pops -> targets C, B, A in order, then ras_valid=0; a 4th pop leaves tos and count unchanged.
REQ-039 Bench SHALL check: 17 pushes with distinct addresses -> count=16, tos=1, and the first-pushed address is overwritten by the 17th.
REQ-040 Bench SHALL check: capture ckpt values (tos=2, count=2), push twice, then redirect_en with a same-cycle pop -> tos=2, count=2, ras_target is the original entry 2.
REQ-041 Bench SHALL check: resetn=0 asserted for one cycle in the middle of a push sequence -> ras_valid=0 and ckpt_count=0 on the next cycle.
REQ-042 Bench SHALL check, with RAS_RECURSION_CNT_EN defined: 3 identical pushes -> count=1; then 3 pops -> ras_valid=1, 1, 1, then 0.
